md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the pipelined CPU's EX stage, beside the ALU.
- Owns the HI/LO register pair and executes MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
- Adds signed MADD/MSUB accumulation.
- Width and per-operation latency are parametrised; a busy flag drives the hazard unit's stall logic for MD-class instructions.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, cycles busy for MULT/MULTU/MADD/MSUB (>=1)
DIV_CYCLES, 10, cycles busy for DIV/DIVU (>=1)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low (0 = reset)
start  input  1  one-cycle strobe: mdOp/srcA/srcB valid this cycle
mdOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MSUB; others = NONE
srcA  input  WIDTH  rs operand
srcB  input  WIDTH  rt operand
busy  output  1  operation in flight
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, async): state IDLE, busy=0, hi=0, lo=0, counter=0, operand latches cleared. Reset mid-operation aborts it; no commit follows.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; counter holds remaining cycles.
- IDLE + start with compute op (1-4, 7, 8):
  - Latch srcA, srcB and mdOp at the edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN: counter decrements each edge. On the edge where counter==1:
  - Commit hi/lo.
  - Return to IDLE.
- Timing, with cycle 0 = start cycle: busy=1 in cycles 1..N. New hi/lo are visible, and busy=0, from cycle N+1. hi/lo hold old values throughout RUN.
- start with MTHI (5) or MTLO (6) in IDLE: hi (or lo) <= srcA at that edge. Single cycle, busy stays 0.
- start with NONE or an undefined op: no effect.
- start while busy=1: ignored entirely, including MTHI/MTLO. The stall logic guarantees it never happens; the bench checks that it is ignored.
- Arithmetic uses the latched operands:
  - MULT: {hi,lo} = signed(A)*signed(B), 2*WIDTH bits.
  - MULTU: unsigned product.
  - MADD: {hi,lo} = {hi,lo} + signed product, mod 2^(2*WIDTH). The {hi,lo} used is the value at commit time, which equals the value at start.
  - MSUB: {hi,lo} = {hi,lo} - signed product, mod 2^(2*WIDTH).
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow (A = most-negative, B = -1): lo = most-negative, hi = 0.
  - Divide by zero (B==0, DIV or DIVU): full DIV_CYCLES busy period, then hi/lo unchanged.
- Result datapath may be computed combinationally from the latches. It is registered only at commit.
- Back-to-back: start is accepted in cycle N+1, the first cycle with busy=0.
- The outputs hi and lo are registers with no bypass. MFHI/MFLO forwarding is the hazard unit's job.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Test Plan:
- Reset low mid-DIV at cycle 4 -> busy=0, hi=0, lo=0 immediately; after release no commit occurs; busy stays 0.
- MULT srcA=0xFFFFFFFF (-1), srcB=0x00000002 -> busy high in cycles 1-5; from cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 with prior hi=0x11, lo=0x22 -> after 10 cycles hi=0x11, lo=0x22.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. MTHI srcA=0x1234 during busy -> ignored, hi is the DIV result.
- MTLO 0x00000005, MTHI 0, then MADD 3*4 -> {hi,lo}=0x0000_0000_0000_0011. MSUB 5*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF8.
- Back-to-back: MULT 6*7 then DIVU 100/7 started in cycle 6 -> hi:lo=0:42 at cycle 6, then busy cycles 7-16, then lo=14, hi=2 at cycle 17. Repeat with WIDTH=16, MULT_CYCLES=1 -> MULT 0x8000*0x8000 gives hi=0x4000, lo=0x0000 one cycle after start.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair; busy holds the
// pipeline while a MULT/DIV-class operation is in flight.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned W2      = 2 * WIDTH;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d;

  logic             sext, is_div, div_zero, neg_a, neg_b;
  logic [W2-1:0]    ext_a, ext_b, prod, acc, res;
  logic [WIDTH-1:0] mag_a, mag_b, divisor, uq, ur, quo, rem;

  // Single multiplier: signed ops sign-extend to 2*WIDTH, unsigned zero-extend
  assign sext  = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign ext_a = sext ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b = sext ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;
  assign acc   = {hi, lo};

  // Signed divide via magnitudes; most-negative / -1 wraps back to most-negative, rem 0
  assign is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign div_zero = (b_q == '0);
  assign neg_a    = (op_q == OP_DIV) && a_q[WIDTH-1];
  assign neg_b    = (op_q == OP_DIV) && b_q[WIDTH-1];
  assign mag_a    = neg_a ? -a_q : a_q;
  assign mag_b    = neg_b ? -b_q : b_q;
  assign divisor  = div_zero ? WIDTH'(1) : mag_b;
  assign uq       = mag_a / divisor;
  assign ur       = mag_a % divisor;
  assign quo      = (neg_a ^ neg_b) ? -uq : uq;
  assign rem      = neg_a ? -ur : ur;

  always_comb begin
    res = prod;
    case (op_q)
      OP_MADD:         res = acc + prod;
      OP_MSUB:         res = acc - prod;
      OP_DIV, OP_DIVU: res = {rem, quo};
      default:         res = prod;
    endcase
  end

  // Next-state: starts are only honoured in IDLE; commit on the last RUN edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi;
    lo_d    = lo;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mdOp)
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              a_d     = srcA;
              b_d     = srcB;
              op_d    = mdOp;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = srcA;
              b_d     = srcB;
              op_d    = mdOp;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = srcA;
            OP_MTLO: lo_d = srcA;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (!(is_div && div_zero)) begin
            hi_d = res[W2-1:WIDTH];
            lo_d = res[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NONE;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi      <= hi_d;
      lo      <= lo_d;
      busy    <= busy_d;
    end
  end

endmodule
